// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the chunked sequential adder.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_CHUNK = 8;

    // Chunk index counter width; never narrower than one bit.
    function automatic int idx_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/adder_seq_chunk.sv
// Combinational CHUNK-bit adder slice with carry-in, carry-out and carry into its MSB.
module adder_seq_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    // Carry into the top bit is recovered from that bit's sum and operands.
    assign c_msb_in = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/adder_seq_chunked.sv
// Multi-cycle wide adder: CHUNK bits per cycle, carry chained through a register.
// Optional signed-overflow output enabled by defining ADDER_SEQ_OVF_EN.
module adder_seq_chunked
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef ADDER_SEQ_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    if ((CHUNK < 1) || (NCHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
        $error("adder_seq_chunked: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic             cout_q;
    logic [CHUNK-1:0] a_chunk, b_chunk, c_sum;
    logic             c_cout, c_msb;
    logic             accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDX_W'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    adder_seq_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_chunk),
        .b        (b_chunk),
        .cin      (carry_q),
        .sum      (c_sum),
        .cout     (c_cout),
        .c_msb_in (c_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset assertion.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) state_nxt = RUN;
            end
            RUN: begin
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_cin;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (idx == IDX_W'(k)) sum_q[k*CHUNK +: CHUNK] <= c_sum;
                    end
                    carry_q <= c_cout;
                    idx     <= idx + 1'b1;
                    if (idx == LAST) cout_q <= c_cout;
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

`ifdef ADDER_SEQ_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            ovf_q <= 1'b0;
        else if ((state == RUN) && (idx == LAST)) ovf_q <= c_msb ^ c_cout;
    end

    assign out_ovf = ovf_q;
`else
    logic unused_c_msb;
    assign unused_c_msb = c_msb;
`endif

endmodule
